// File: rtl/reg_dump_if.sv
// Bundle of the reg_dump control, register-file read and word-stream signals.
// master: host/consumer/reg_file side; slave: the reg_dump sequencer.
interface reg_dump_if;
    logic        Start;
    logic [4:0]  StartAddr;
    logic [5:0]  Count;
    logic [4:0]  Ard1;
    logic [4:0]  Ard2;
    logic [31:0] Dout1;
    logic [31:0] Dout2;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutData;
    logic [4:0]  OutAddr;
    logic        Busy;
    logic        Done;
    logic [31:0] Csum;

    modport master (
        output Start, StartAddr, Count, Dout1, Dout2, OutReady,
        input  Ard1, Ard2, OutValid, OutData, OutAddr, Busy, Done, Csum
    );

    modport slave (
        input  Start, StartAddr, Count, Dout1, Dout2, OutReady,
        output Ard1, Ard2, OutValid, OutData, OutAddr, Busy, Done, Csum
    );
endinterface

// File: rtl/reg_dump.sv
// Debug read-out sequencer: walks a register range two at a time and streams the words.
// Define REG_DUMP_CSUM_EN to keep a running XOR checksum of the sent words on Csum.
module reg_dump (
    input  logic     Clk,
    input  logic     Rst_n,
    reg_dump_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend0,
        StSend1,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] buf0_q, buf0_d;
    logic [31:0] buf1_q, buf1_d;
    logic [4:0]  ptr_plus1;
    logic [5:0]  count_clamped;

    assign ptr_plus1     = ptr_q + 5'd1;
    assign count_clamped = (bus.Count > 6'd32) ? 6'd32 : bus.Count;

`ifdef REG_DUMP_CSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 5'd0;
            rem_q   <= 6'd0;
            buf0_q  <= 32'd0;
            buf1_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

`ifdef REG_DUMP_CSUM_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            csum_q <= 32'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
`ifdef REG_DUMP_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    ptr_d   = bus.StartAddr;
                    rem_d   = count_clamped;
`ifdef REG_DUMP_CSUM_EN
                    csum_d  = 32'd0;
`endif
                    state_d = (count_clamped == 6'd0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                buf0_d  = bus.Dout1;
                buf1_d  = bus.Dout2;
                state_d = StSend0;
            end
            StSend0: begin
                if (bus.OutReady) begin
                    rem_d   = rem_q - 6'd1;
`ifdef REG_DUMP_CSUM_EN
                    csum_d  = csum_q ^ buf0_q;
`endif
                    state_d = (rem_q == 6'd1) ? StDone : StSend1;
                end
            end
            StSend1: begin
                if (bus.OutReady) begin
                    rem_d   = rem_q - 6'd1;
                    ptr_d   = ptr_q + 5'd2;
`ifdef REG_DUMP_CSUM_EN
                    csum_d  = csum_q ^ buf1_q;
`endif
                    state_d = (rem_q == 6'd1) ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read addresses follow ptr in every state so reg_file data is settled by FETCH.
    always_comb begin
        bus.Ard1     = ptr_q;
        bus.Ard2     = ptr_plus1;
        bus.OutValid = 1'b0;
        bus.OutData  = 32'd0;
        bus.OutAddr  = 5'd0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        case (state_q)
            StFetch: begin
                bus.Busy = 1'b1;
            end
            StSend0: begin
                bus.Busy     = 1'b1;
                bus.OutValid = 1'b1;
                bus.OutData  = buf0_q;
                bus.OutAddr  = ptr_q;
            end
            StSend1: begin
                bus.Busy     = 1'b1;
                bus.OutValid = 1'b1;
                bus.OutData  = buf1_q;
                bus.OutAddr  = ptr_plus1;
            end
            StDone: begin
                bus.Done = 1'b1;
            end
            default: begin
                bus.Busy = 1'b0;
            end
        endcase
    end

`ifdef REG_DUMP_CSUM_EN
    assign bus.Csum = csum_q;
`else
    assign bus.Csum = 32'd0;
`endif

    busy_done_exclusive : assert property (@(posedge Clk) !(bus.Busy && bus.Done));

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump with a behavioural combinational register file.
module tb_reg_dump;

`ifdef REG_DUMP_CSUM_EN
    localparam bit CsumOn = 1'b1;
`else
    localparam bit CsumOn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] regs [32];
    int          checks;
    int          failures;

    reg_dump_if bus ();

    reg_dump dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.Dout1 = regs[bus.Ard1];
    assign bus.Dout2 = regs[bus.Ard2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.Start = 1'b0; bus.StartAddr = 5'd0; bus.Count = 6'd0; bus.OutReady = 1'b0;
        tick; tick;
        checks++; if (bus.Ard1 !== 5'd0) begin failures++; $display("FAIL reset_ard1 got=%0d exp=0", bus.Ard1); end
        checks++; if (bus.Ard2 !== 5'd1) begin failures++; $display("FAIL reset_ard2 got=%0d exp=1", bus.Ard2); end
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.OutValid); end
        checks++; if (bus.OutData !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.OutData); end
        checks++; if (bus.OutAddr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.OutAddr); end
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
        checks++; if (bus.Csum !== 32'd0) begin failures++; $display("FAIL reset_csum got=%0h exp=0", bus.Csum); end
        rst_n = 1'b1;
        tick;
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.Busy); end
    endtask

    task automatic test_basic;
        logic [31:0] exp_csum;
        exp_csum = CsumOn ? 32'd34 : 32'd0;
        regs[3] = 32'd32; regs[4] = 32'd2;
        bus.Start = 1'b1; bus.StartAddr = 5'd3; bus.Count = 6'd2; bus.OutReady = 1'b1;
        tick;  // FETCH
        bus.Start = 1'b0;
        checks++; if (bus.Busy !== 1'b1 || bus.OutValid !== 1'b0) begin failures++; $display("FAIL basic_fetch busy=%b valid=%b exp busy=1 valid=0", bus.Busy, bus.OutValid); end
        checks++; if (bus.Ard1 !== 5'd3 || bus.Ard2 !== 5'd4) begin failures++; $display("FAIL basic_ard got=%0d/%0d exp=3/4", bus.Ard1, bus.Ard2); end
        tick;  // SEND0
        checks++; if (bus.OutValid !== 1'b1 || bus.OutAddr !== 5'd3 || bus.OutData !== 32'd32) begin failures++; $display("FAIL basic_w0 valid=%b addr=%0d data=%0d exp 1/3/32", bus.OutValid, bus.OutAddr, bus.OutData); end
        tick;  // SEND1
        checks++; if (bus.OutValid !== 1'b1 || bus.OutAddr !== 5'd4 || bus.OutData !== 32'd2) begin failures++; $display("FAIL basic_w1 valid=%b addr=%0d data=%0d exp 1/4/2", bus.OutValid, bus.OutAddr, bus.OutData); end
        tick;  // DONE
        checks++; if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.OutValid !== 1'b0) begin failures++; $display("FAIL basic_done done=%b busy=%b valid=%b exp 1/0/0", bus.Done, bus.Busy, bus.OutValid); end
        checks++; if (bus.Csum !== exp_csum) begin failures++; $display("FAIL basic_csum got=%0d exp=%0d", bus.Csum, exp_csum); end
        tick;  // IDLE
        checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", bus.Done); end
        checks++; if (bus.Csum !== exp_csum) begin failures++; $display("FAIL basic_csum_hold got=%0d exp=%0d", bus.Csum, exp_csum); end
    endtask

    task automatic test_count0;
        bus.Start = 1'b1; bus.StartAddr = 5'd7; bus.Count = 6'd0; bus.OutReady = 1'b1;
        tick;
        bus.Start = 1'b0;
        checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL count0_done got=%b exp=1", bus.Done); end
        checks++; if (bus.Busy !== 1'b0 || bus.OutValid !== 1'b0) begin failures++; $display("FAIL count0_idle busy=%b valid=%b exp 0/0", bus.Busy, bus.OutValid); end
        checks++; if (bus.Csum !== 32'd0) begin failures++; $display("FAIL count0_csum got=%0d exp=0", bus.Csum); end
        tick;
        checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin failures++; $display("FAIL count0_after done=%b busy=%b exp 0/0", bus.Done, bus.Busy); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_csum;
        exp_csum = CsumOn ? 32'd14 : 32'd0;
        regs[31] = 32'd7; regs[0] = 32'd0; regs[1] = 32'd9;
        bus.Start = 1'b1; bus.StartAddr = 5'd31; bus.Count = 6'd3; bus.OutReady = 1'b1;
        tick;  // FETCH
        bus.Start = 1'b0;
        checks++; if (bus.Ard1 !== 5'd31 || bus.Ard2 !== 5'd0) begin failures++; $display("FAIL wrap_ard0 got=%0d/%0d exp=31/0", bus.Ard1, bus.Ard2); end
        tick;
        checks++; if (bus.OutAddr !== 5'd31 || bus.OutData !== 32'd7) begin failures++; $display("FAIL wrap_w0 addr=%0d data=%0d exp 31/7", bus.OutAddr, bus.OutData); end
        tick;
        checks++; if (bus.OutAddr !== 5'd0 || bus.OutData !== 32'd0 || bus.OutValid !== 1'b1) begin failures++; $display("FAIL wrap_w1 addr=%0d data=%0d valid=%b exp 0/0/1", bus.OutAddr, bus.OutData, bus.OutValid); end
        tick;  // FETCH
        checks++; if (bus.Ard1 !== 5'd1 || bus.Ard2 !== 5'd2) begin failures++; $display("FAIL wrap_ard1 got=%0d/%0d exp=1/2", bus.Ard1, bus.Ard2); end
        tick;
        checks++; if (bus.OutAddr !== 5'd1 || bus.OutData !== 32'd9) begin failures++; $display("FAIL wrap_w2 addr=%0d data=%0d exp 1/9", bus.OutAddr, bus.OutData); end
        tick;
        checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", bus.Done); end
        checks++; if (bus.Csum !== exp_csum) begin failures++; $display("FAIL wrap_csum got=%0d exp=%0d", bus.Csum, exp_csum); end
        tick;
    endtask

    task automatic test_stall;
        regs[3] = 32'd32; regs[4] = 32'd2;
        bus.Start = 1'b1; bus.StartAddr = 5'd3; bus.Count = 6'd2; bus.OutReady = 1'b0;
        tick;
        bus.Start = 1'b0;
        tick;  // SEND0, stalled
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.OutValid !== 1'b1 || bus.OutAddr !== 5'd3 || bus.OutData !== 32'd32) begin failures++; $display("FAIL stall_hold%0d valid=%b addr=%0d data=%0d exp 1/3/32", i, bus.OutValid, bus.OutAddr, bus.OutData); end
            tick;
        end
        bus.OutReady = 1'b1;
        checks++; if (bus.OutAddr !== 5'd3 || bus.OutData !== 32'd32) begin failures++; $display("FAIL stall_release addr=%0d data=%0d exp 3/32", bus.OutAddr, bus.OutData); end
        tick;
        checks++; if (bus.OutAddr !== 5'd4 || bus.OutData !== 32'd2) begin failures++; $display("FAIL stall_w1 addr=%0d data=%0d exp 4/2", bus.OutAddr, bus.OutData); end
        tick;
        checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", bus.Done); end
        tick;
    endtask

    task automatic test_start_ignored;
        int words;
        words = 0;
        regs[3] = 32'd32; regs[4] = 32'd2; regs[10] = 32'hCAFE_0010;
        bus.Start = 1'b1; bus.StartAddr = 5'd3; bus.Count = 6'd2; bus.OutReady = 1'b1;
        tick;
        bus.Start = 1'b0;
        tick;
        if (bus.OutValid === 1'b1) words++;
        tick;  // SEND1
        if (bus.OutValid === 1'b1) words++;
        bus.Start = 1'b1; bus.StartAddr = 5'd10; bus.Count = 6'd5;
        tick;  // DONE despite Start
        checks++; if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin failures++; $display("FAIL ign_done done=%b busy=%b exp 1/0", bus.Done, bus.Busy); end
        tick;  // Start during DONE ignored -> IDLE
        checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin failures++; $display("FAIL ign_idle busy=%b done=%b exp 0/0", bus.Busy, bus.Done); end
        checks++; if (words !== 2) begin failures++; $display("FAIL ign_words got=%0d exp=2", words); end
        bus.Count = 6'd1;
        tick;  // fresh dump accepted
        bus.Start = 1'b0;
        checks++; if (bus.Busy !== 1'b1 || bus.Ard1 !== 5'd10) begin failures++; $display("FAIL fresh_fetch busy=%b ard1=%0d exp 1/10", bus.Busy, bus.Ard1); end
        tick;
        checks++; if (bus.OutAddr !== 5'd10 || bus.OutData !== 32'hCAFE_0010) begin failures++; $display("FAIL fresh_w0 addr=%0d data=%0h exp 10/cafe0010", bus.OutAddr, bus.OutData); end
        tick;
        checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL fresh_done got=%b exp=1", bus.Done); end
        tick;
    endtask

    task automatic test_count40;
        int          n;
        int          done_at;
        logic [4:0]  ea;
        logic [31:0] exp_csum;
        n = 0; done_at = 0; exp_csum = 32'd0;
        for (int i = 0; i < 32; i++) regs[i] = (32'(i) * 32'h0101_0301) ^ 32'h5A00_0000;
        bus.Start = 1'b1; bus.StartAddr = 5'd5; bus.Count = 6'd40; bus.OutReady = 1'b1;
        for (int k = 1; k <= 200 && done_at == 0; k++) begin
            tick;
            if (k == 1) bus.Start = 1'b0;
            if (bus.Done === 1'b1) begin
                done_at = k;
            end else if (bus.OutValid === 1'b1) begin
                ea = 5'(5 + n);
                checks++; if (bus.OutAddr !== ea || bus.OutData !== regs[ea]) begin failures++; $display("FAIL c40_word%0d addr=%0d data=%0h exp %0d/%0h", n, bus.OutAddr, bus.OutData, ea, regs[ea]); end
                exp_csum = exp_csum ^ regs[ea];
                n++;
            end
        end
        if (!CsumOn) exp_csum = 32'd0;
        checks++; if (n !== 32) begin failures++; $display("FAIL c40_count got=%0d exp=32", n); end
        checks++; if (done_at !== 49) begin failures++; $display("FAIL c40_latency got=%0d exp=49", done_at); end
        checks++; if (bus.Csum !== exp_csum) begin failures++; $display("FAIL c40_csum got=%0h exp=%0h", bus.Csum, exp_csum); end
        tick;
    endtask

    task automatic test_reset_mid;
        regs[3] = 32'd32; regs[4] = 32'd2;
        bus.Start = 1'b1; bus.StartAddr = 5'd3; bus.Count = 6'd4; bus.OutReady = 1'b1;
        tick;
        bus.Start = 1'b0;
        tick; tick;  // SEND1
        checks++; if (bus.OutValid !== 1'b1 || bus.OutAddr !== 5'd4) begin failures++; $display("FAIL rmid_send1 valid=%b addr=%0d exp 1/4", bus.OutValid, bus.OutAddr); end
        rst_n = 1'b0;
        tick;
        checks++; if (bus.OutValid !== 1'b0 || bus.OutData !== 32'd0 || bus.OutAddr !== 5'd0) begin failures++; $display("FAIL rmid_out valid=%b data=%0h addr=%0d exp 0/0/0", bus.OutValid, bus.OutData, bus.OutAddr); end
        checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Csum !== 32'd0) begin failures++; $display("FAIL rmid_status busy=%b done=%b csum=%0h exp 0/0/0", bus.Busy, bus.Done, bus.Csum); end
        checks++; if (bus.Ard1 !== 5'd0 || bus.Ard2 !== 5'd1) begin failures++; $display("FAIL rmid_ard got=%0d/%0d exp=0/1", bus.Ard1, bus.Ard2); end
        rst_n = 1'b1;
        tick;
        checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin failures++; $display("FAIL rmid_after done=%b busy=%b exp 0/0", bus.Done, bus.Busy); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD_0000 | 32'(i);
        test_reset;
        test_basic;
        test_count0;
        test_wrap;
        test_stall;
        test_start_ignored;
        test_count40;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
